// File: rtl/if_fetch_queue.sv
// Fetch stage: owns the PC, keeps one ICache fetch outstanding, predicts JAL/B-type
// targets with a 2-bit BHT and buffers fetched instructions in a FWFT queue for decode.
module if_fetch_queue #(
    parameter int                  PC_WIDTH     = 32,
    parameter int                  QUEUE_DEPTH  = 8,
    parameter int                  BHT_IDX_BITS = 6,
    parameter logic [PC_WIDTH-1:0] RESET_PC     = '0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               rdy,
    input  logic                               jp_wrong,
    input  logic [PC_WIDTH-1:0]                jp_pc,
    input  logic                               bht_upd_valid,
    input  logic [PC_WIDTH-1:0]                bht_upd_pc,
    input  logic                               bht_upd_taken,
    output logic                               ic_req_valid,
    output logic [PC_WIDTH-1:0]                ic_req_pc,
    input  logic                               ic_req_ready,
    input  logic                               ic_rsp_valid,
    input  logic [31:0]                        ic_rsp_ins,
    output logic                               id_valid,
    output logic [31:0]                        id_ins,
    output logic [PC_WIDTH-1:0]                id_pc,
    output logic                               id_pred_taken,
    output logic [PC_WIDTH-1:0]                id_pred_pc,
    input  logic                               id_ready,
    output logic [$clog2(QUEUE_DEPTH):0]       q_count
);

    localparam int PTR_W    = $clog2(QUEUE_DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int BHT_SIZE = 2 ** BHT_IDX_BITS;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DISCARD} state_t;

    state_t                  state, state_nxt;
    logic [PC_WIDTH-1:0]     pc;
    logic [1:0]              bht [BHT_SIZE];
    logic [PTR_W-1:0]        rd_ptr, wr_ptr;
    logic [CNT_W-1:0]        count;

    logic [31:0]             ins_q  [QUEUE_DEPTH];
    logic [PC_WIDTH-1:0]     pc_q   [QUEUE_DEPTH];
    logic                    ptk_q  [QUEUE_DEPTH];
    logic [PC_WIDTH-1:0]     ppc_q  [QUEUE_DEPTH];

    logic                    push, pop, req_fire;
    logic                    pred_taken;
    logic [PC_WIDTH-1:0]     pred_pc;
    logic [BHT_IDX_BITS-1:0] lk_idx, upd_idx;
    logic                    unused_bits;

    function automatic logic signed [PC_WIDTH-1:0] imm_j(input logic [31:0] ins);
        logic signed [20:0] imm;
        imm = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        return PC_WIDTH'(imm);
    endfunction

    function automatic logic signed [PC_WIDTH-1:0] imm_b(input logic [31:0] ins);
        logic signed [12:0] imm;
        imm = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        return PC_WIDTH'(imm);
    endfunction

    function automatic logic [1:0] bht_next(input logic [1:0] ctr, input logic taken);
        if (taken) return (ctr == 2'b11) ? ctr : ctr + 2'b01;
        else       return (ctr == 2'b00) ? ctr : ctr - 2'b01;
    endfunction

    assign lk_idx      = pc[BHT_IDX_BITS+1:2];
    assign upd_idx     = bht_upd_pc[BHT_IDX_BITS+1:2];
    assign unused_bits = ^{bht_upd_pc[PC_WIDTH-1:BHT_IDX_BITS+2], bht_upd_pc[1:0]};

    // Prediction is formed on the returning instruction against the PC still held in WAIT
    always_comb begin
        pred_taken = 1'b0;
        pred_pc    = pc + PC_WIDTH'(4);
        case (ic_rsp_ins[6:0])
            OP_JAL: begin
                pred_taken = 1'b1;
                pred_pc    = pc + imm_j(ic_rsp_ins);
            end
            OP_BRANCH: begin
                if (bht[lk_idx][1]) begin
                    pred_taken = 1'b1;
                    pred_pc    = pc + imm_b(ic_rsp_ins);
                end
            end
            default: ;
        endcase
    end

    assign ic_req_valid = rdy & ~jp_wrong & (state == S_REQ) & (count < CNT_W'(QUEUE_DEPTH));
    assign ic_req_pc    = pc;
    assign req_fire     = ic_req_valid & ic_req_ready;
    assign push         = rdy & ~jp_wrong & (state == S_WAIT) & ic_rsp_valid;
    assign pop          = rdy & ~jp_wrong & id_valid & id_ready;

    assign id_valid      = (count != '0);
    assign id_ins        = id_valid ? ins_q[rd_ptr] : '0;
    assign id_pc         = id_valid ? pc_q[rd_ptr]  : '0;
    assign id_pred_taken = id_valid ? ptk_q[rd_ptr] : 1'b0;
    assign id_pred_pc    = id_valid ? ppc_q[rd_ptr] : '0;
    assign q_count       = count;

    always_comb begin
        state_nxt = state;
        if (rdy) begin
            if (jp_wrong) begin
                // A response landing in the flush cycle settles the outstanding fetch
                case (state)
                    S_REQ:   state_nxt = S_REQ;
                    default: state_nxt = ic_rsp_valid ? S_REQ : S_DISCARD;
                endcase
            end else begin
                case (state)
                    S_REQ:     if (req_fire)     state_nxt = S_WAIT;
                    S_WAIT:    if (ic_rsp_valid) state_nxt = S_REQ;
                    S_DISCARD: if (ic_rsp_valid) state_nxt = S_REQ;
                    default:                     state_nxt = S_REQ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_REQ;
            pc     <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < BHT_SIZE; i++) bht[i] <= 2'b01;
        end else if (rdy) begin
            state <= state_nxt;
            if (bht_upd_valid) bht[upd_idx] <= bht_next(bht[upd_idx], bht_upd_taken);
            if (jp_wrong) begin
                pc     <= jp_pc;
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    pc     <= pred_pc;
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
                case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ins_q[wr_ptr] <= ic_rsp_ins;
            pc_q[wr_ptr]  <= pc;
            ptk_q[wr_ptr] <= pred_taken;
            ppc_q[wr_ptr] <= pred_pc;
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: a hand-driven ICache/decoder/ROB around the DUT,
// with each expected value worked out by hand for the instruction sequence below.
module tb_if_fetch_queue;

    localparam logic [31:0] ADDI   = 32'h0010_0093;  // addi x1,x0,1
    localparam logic [31:0] JAL100 = 32'h1000_006F;  // jal x0,+0x100
    localparam logic [31:0] BEQM8  = 32'hFE00_0CE3;  // beq x0,x0,-8

    logic        clk = 1'b0;
    logic        rst_n, rdy, jp_wrong, bht_upd_valid, bht_upd_taken;
    logic [31:0] jp_pc, bht_upd_pc;
    logic        ic_req_valid, ic_req_ready, ic_rsp_valid;
    logic [31:0] ic_req_pc, ic_rsp_ins;
    logic        id_valid, id_pred_taken, id_ready;
    logic [31:0] id_ins, id_pc, id_pred_pc;
    logic [3:0]  q_count;

    int vectors = 0;
    int errs    = 0;
    logic [31:0] rpc;

    if_fetch_queue dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .jp_wrong(jp_wrong), .jp_pc(jp_pc),
        .bht_upd_valid(bht_upd_valid), .bht_upd_pc(bht_upd_pc), .bht_upd_taken(bht_upd_taken),
        .ic_req_valid(ic_req_valid), .ic_req_pc(ic_req_pc), .ic_req_ready(ic_req_ready),
        .ic_rsp_valid(ic_rsp_valid), .ic_rsp_ins(ic_rsp_ins),
        .id_valid(id_valid), .id_ins(id_ins), .id_pc(id_pc), .id_pred_taken(id_pred_taken),
        .id_pred_pc(id_pred_pc), .id_ready(id_ready), .q_count(q_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Accept one request and return ins the following cycle; hands back the request PC
    task automatic serve(input logic [31:0] ins, output logic [31:0] req_pc);
        int n = 0;
        while (!ic_req_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("serve_req_valid", ic_req_valid, 1);
        req_pc       = ic_req_pc;
        ic_req_ready = 1'b1;
        @(negedge clk);
        ic_req_ready = 1'b0;
        ic_rsp_valid = 1'b1;
        ic_rsp_ins   = ins;
        @(negedge clk);
        ic_rsp_valid = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] target);
        jp_wrong = 1'b1;
        jp_pc    = target;
        #1 chk("flush_no_req", ic_req_valid, 0);
        @(negedge clk);
        jp_wrong = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1; rdy = 1'b0; jp_wrong = 1'b0; jp_pc = '0;
        bht_upd_valid = 1'b0; bht_upd_pc = '0; bht_upd_taken = 1'b0;
        ic_req_ready = 1'b0; ic_rsp_valid = 1'b0; ic_rsp_ins = '0; id_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req_valid", ic_req_valid, 0);
        chk("rst_req_pc", ic_req_pc, 32'h0);
        chk("rst_id_valid", id_valid, 0);
        chk("rst_id_ins", id_ins, 0);
        chk("rst_id_pred_pc", id_pred_pc, 0);
        chk("rst_q_count", q_count, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rdy_low_no_req", ic_req_valid, 0);
        rdy = 1'b1;
        #1 chk("rdy_high_req", ic_req_valid, 1);

        // Sequential ADDIs from 0x0
        for (int i = 0; i < 4; i++) begin
            serve(ADDI, rpc);
            chk("seq_req_pc", rpc, 32'(4 * i));
            chk("seq_id_pc", id_pc, 32'(4 * i));
            chk("seq_id_ins", id_ins, ADDI);
            chk("seq_pred_tk", id_pred_taken, 0);
            chk("seq_pred_pc", id_pred_pc, 32'(4 * i + 4));
            chk("seq_count", q_count, 1);
        end

        // JAL +0x100 at 0x10
        serve(JAL100, rpc);
        chk("jal_req_pc", rpc, 32'h10);
        chk("jal_pred_tk", id_pred_taken, 1);
        chk("jal_pred_pc", id_pred_pc, 32'h110);
        serve(ADDI, rpc);
        chk("jal_next_req", rpc, 32'h110);

        // BEQ -8 at 0x20: weak not-taken, then two taken updates
        redirect(32'h20);
        chk("redir_count", q_count, 0);
        serve(BEQM8, rpc);
        chk("beq_req_pc", rpc, 32'h20);
        chk("beq_nt_tk", id_pred_taken, 0);
        chk("beq_nt_pc", id_pred_pc, 32'h24);
        bht_upd_valid = 1'b1; bht_upd_pc = 32'h20; bht_upd_taken = 1'b1;
        repeat (2) @(negedge clk);
        bht_upd_valid = 1'b0;
        redirect(32'h20);
        serve(BEQM8, rpc);
        chk("beq_t_tk", id_pred_taken, 1);
        chk("beq_t_pc", id_pred_pc, 32'h18);

        // Fill the queue with the decoder stalled
        id_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            serve(ADDI, rpc);
            chk("fill_req_pc", rpc, 32'(32'h18 + 4 * i));
        end
        chk("full_count", q_count, 8);
        chk("full_no_req", ic_req_valid, 0);
        repeat (2) @(negedge clk);
        chk("full_hold_count", q_count, 8);
        chk("full_hold_no_req", ic_req_valid, 0);
        chk("full_head_pc", id_pc, 32'h20);
        id_ready = 1'b1;
        @(negedge clk);
        id_ready = 1'b0;
        chk("pop_count", q_count, 7);
        chk("pop_head_pc", id_pc, 32'h18);
        chk("pop_req_valid", ic_req_valid, 1);
        chk("pop_req_pc", ic_req_pc, 32'h34);
        serve(ADDI, rpc);
        chk("refill_count", q_count, 8);
        chk("refill_no_req", ic_req_valid, 0);

        // Drain, then flush while a fetch is outstanding
        id_ready = 1'b1;
        repeat (9) @(negedge clk);
        chk("drain_count", q_count, 0);
        id_ready = 1'b0;
        serve(ADDI, rpc);
        serve(ADDI, rpc);
        chk("pre_flush_count", q_count, 2);
        ic_req_ready = 1'b1;
        @(negedge clk);
        ic_req_ready = 1'b0;
        redirect(32'h200);
        chk("flush_count", q_count, 0);
        chk("flush_id_valid", id_valid, 0);
        chk("discard_no_req", ic_req_valid, 0);
        ic_rsp_valid = 1'b1; ic_rsp_ins = ADDI;
        @(negedge clk);
        ic_rsp_valid = 1'b0;
        chk("stale_dropped", q_count, 0);
        chk("post_flush_req", ic_req_valid, 1);
        chk("post_flush_pc", ic_req_pc, 32'h200);

        // Async reset while waiting on a fetch with three entries queued
        for (int i = 0; i < 3; i++) serve(ADDI, rpc);
        chk("pre_rst_count", q_count, 3);
        ic_req_ready = 1'b1;
        @(negedge clk);
        ic_req_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_count", q_count, 0);
        chk("mid_rst_pc", ic_req_pc, 32'h0);
        chk("mid_rst_id_valid", id_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ic_rsp_valid = 1'b1; ic_rsp_ins = ADDI;
        @(negedge clk);
        ic_rsp_valid = 1'b0;
        chk("late_rsp_ignored", q_count, 0);
        chk("late_rsp_pc", ic_req_pc, 32'h0);
        id_ready = 1'b1;
        redirect(32'h20);
        serve(BEQM8, rpc);
        chk("bht_rst_tk", id_pred_taken, 0);
        chk("bht_rst_pc", id_pred_pc, 32'h24);
        bht_upd_valid = 1'b1; bht_upd_pc = 32'h20; bht_upd_taken = 1'b1;
        @(negedge clk);
        bht_upd_valid = 1'b0;
        redirect(32'h20);
        serve(BEQM8, rpc);
        chk("bht_one_up_tk", id_pred_taken, 1);
        chk("bht_one_up_pc", id_pred_pc, 32'h18);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
